// File: rtl/chaos_pixel_diffuser.sv
// chaos_pixel_diffuser: chained add-XOR diffusion of a streamed image.
// Three extractor values become three key bytes. They are used in rotation,
// one byte per pixel, and a new triple is requested every third pixel.
// The same datapath encrypts or decrypts; the mode is latched at image start.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge when
// valid & ready are both high. Once valid is raised, the producer holds the
// data stable until the transfer. ready may depend combinationally on the
// consumer's own ready (pix_ready follows out_ready), but never on valid.
module chaos_pixel_diffuser #(
  parameter int          NUM_PIXELS = 65536,
  parameter int          CNT_W      = 17,
  parameter logic [7:0]  IV         = 8'h5A
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          decrypt,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [22:0]   ex1,
  input  logic [22:0]   ex2,
  input  logic [22:0]   ex3,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

  state_t           state;
  logic [7:0]       chain;
  logic [1:0]       kidx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       key0, key1, key2;
  logic             mode;

  logic [7:0]       k_cur;
  logic [7:0]       y_enc;
  logic [7:0]       y_dec;
  logic [7:0]       y;
  logic             pix_acc;
  logic             out_acc;

  // Extractor bits 22:10 carry no key material.
  logic unused_ex_bits;
  assign unused_ex_bits = ^{ex1[22:10], ex2[22:10], ex3[22:10]};

  // Status and ready strobes are decoded from the state register only.
  assign key_ready = (state == LOAD_KEY);
  assign busy      = (state != IDLE);
  // One-entry output register: refillable in the cycle it drains.
  assign pix_ready = (state == RUN) && (!out_valid || out_ready);
  assign pix_acc   = pix_valid && pix_ready;
  assign out_acc   = out_valid && out_ready;

  // Select the key byte for the current position in the key group.
  always_comb begin
    k_cur = key0;
    case (kidx)
      2'd1:    k_cur = key1;
      2'd2:    k_cur = key2;
      default: k_cur = key0;
    endcase
  end

  // Encrypt chains on the cipher output, decrypt chains on the cipher input,
  // so both directions see the same chain sequence.
  assign y_enc = (pix_data + k_cur) ^ chain;
  assign y_dec = (pix_data ^ chain) - k_cur;
  assign y     = mode ? y_dec : y_enc;

  // Control FSM, key capture, chaining state and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      chain     <= IV;
      kidx      <= 2'd0;
      cnt       <= '0;
      key0      <= 8'h00;
      key1      <= 8'h00;
      key2      <= 8'h00;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pix_acc) begin
        out_valid <= 1'b1;
        out_data  <= y;
      end else if (out_acc) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_KEY;
            cnt   <= '0;
            chain <= IV;
            mode  <= decrypt;
          end
        end
        LOAD_KEY: begin
          if (key_valid) begin
            key0  <= ex1[7:0] ^ {6'b0, ex1[9:8]};
            key1  <= ex2[7:0] ^ {6'b0, ex2[9:8]};
            key2  <= ex3[7:0] ^ {6'b0, ex3[9:8]};
            kidx  <= 2'd0;
            state <= RUN;
          end
        end
        RUN: begin
          if (pix_acc) begin
            chain <= mode ? pix_data : y_enc;
            kidx  <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_PIX) begin
              state <= DRAIN;
            end else if (kidx == 2'd2) begin
              state <= LOAD_KEY;
            end
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_pixel_diffuser.sv
// Bench for chaos_pixel_diffuser (4-pixel images, so every image spans two
// key groups). A reference model pushes expected bytes when a pixel is
// accepted; a monitor pops and compares on every output transfer.
module tb_chaos_pixel_diffuser;

  localparam int         NP  = 4;
  localparam logic [7:0] IVV = 8'h5A;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [22:0] ex1, ex2, ex3;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  chaos_pixel_diffuser #(
    .NUM_PIXELS (NP),
    .CNT_W      (17),
    .IV         (IVV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .decrypt   (decrypt),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .ex1       (ex1),
    .ex2       (ex2),
    .ex3       (ex3),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         acc_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         key_hs   = 0;

  logic [7:0] mk[3];
  logic [7:0] m_chain;
  int         m_idx;
  logic       m_dec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] kb(input logic [22:0] e);
    return e[7:0] ^ {6'b0, e[9:8]};
  endfunction

  task automatic model_pixel(input logic [7:0] p);
    logic [7:0] k;
    logic [7:0] yv;
    k = mk[m_idx];
    if (m_dec) begin
      yv      = (p ^ m_chain) - k;
      m_chain = p;
    end else begin
      yv      = (p + k) ^ m_chain;
      m_chain = yv;
    end
    exp_q.push_back(yv);
    m_idx = (m_idx + 1) % 3;
  endtask

  // Output monitor: compares every output transfer against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_extra", exp_q.size(), 1);
        else                   check("out_data", out_data, exp_q.pop_front());
        acc_cyc.push_back(cyc);
      end
      if (key_valid && key_ready) key_hs++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_with_done", busy, 0);
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic start_image(input logic dec);
    start   = 1'b1;
    decrypt = dec;
    @(posedge clk); #1;
    start   = 1'b0;
    m_chain = IVV;
    m_idx   = 0;
    m_dec   = dec;
  endtask

  task automatic give_key(input logic [22:0] e1, input logic [22:0] e2, input logic [22:0] e3);
    int n = 0;
    bit got = 0;
    key_valid = 1'b1;
    ex1 = e1; ex2 = e2; ex3 = e3;
    while (!got && n < 50) begin
      @(negedge clk);
      if (key_ready) got = 1;
      n++;
    end
    if (!got) check("key_wait_timeout", {31'b0, got}, 1);
    mk[0] = kb(e1); mk[1] = kb(e2); mk[2] = kb(e3);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] p);
    int n = 0;
    bit got = 0;
    pix_valid = 1'b1;
    pix_data  = p;
    while (!got && n < 50) begin
      @(negedge clk);
      if (pix_ready) got = 1;
      n++;
    end
    if (got) model_pixel(p);
    else     check("pix_wait_timeout", {31'b0, got}, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    bit got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (done) got = 1;
      n++;
    end
    if (!got) check("done_timeout", {31'b0, got}, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int key_base;
    int done_base;
    int last_acc;
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_valid = 1'b0;
    ex1 = '0; ex2 = '0; ex3 = '0;
    pix_valid = 1'b0; pix_data = 8'h00; out_ready = 1'b1;
    mk[0] = 8'h00; mk[1] = 8'h00; mk[2] = 8'h00;
    m_chain = IVV; m_idx = 0; m_dec = 1'b0;

    // Reset values
    #12;
    check("rst_key_ready", key_ready, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // A: encrypt 10,20,FF,80; second key group supplies pixel 3's key
    key_base = key_hs;
    start_image(1'b0);
    check("A_busy_rise", busy, 1);
    check("A_key_ready", key_ready, 1);
    give_key(23'd5, 23'd300, 23'd999);
    send_pix(8'h10);
    send_pix(8'h20);
    send_pix(8'hFF);
    give_key(23'h7, 23'h133, 23'h0);
    send_pix(8'h80);
    pix_valid = 1'b0;
    wait_done();
    last_acc = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] : -10;
    check("A_done_after_last_out", done_cyc - last_acc, 1);
    check("A_key_requests", key_hs - key_base, 2);
    check("A_done_one_cycle", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("A_no_third_key_req", key_ready, 0);
    end
    check("A_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // B: decrypt with a 5-cycle output stall after the first byte
    start_image(1'b1);
    give_key(23'd5, 23'd300, 23'd999);
    out_ready = 1'b0;
    send_pix(8'h4F);
    pix_data = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("B_stall_out_valid", out_valid, 1);
      check("B_stall_out_data", out_data, 8'h10);
      check("B_stall_pix_ready", pix_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_pix(8'h02);
    send_pix(8'hE1);
    give_key(23'h7, 23'h133, 23'h0);
    send_pix(8'h66);
    pix_valid = 1'b0;
    wait_done();
    check("B_queue_empty", exp_q.size(), 0);

    // C: key_valid and start pulsed mid-image are ignored
    done_base = done_cnt;
    start_image(1'b0);
    give_key(23'd5, 23'd300, 23'd999);
    send_pix(8'h10);
    pix_valid = 1'b0;
    key_valid = 1'b1; ex1 = 23'h0; ex2 = 23'h0; ex3 = 23'h0;
    @(negedge clk);
    check("C_key_ready_in_run", key_ready, 0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("C_busy_mid_image", busy, 1);
    send_pix(8'h20);
    send_pix(8'hFF);
    give_key(23'h7, 23'h133, 23'h0);
    send_pix(8'h80);
    pix_valid = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("C_one_done", done_cnt - done_base, 1);
    check("C_no_restart", busy, 0);
    check("C_queue_empty", exp_q.size(), 0);

    // D: async reset with a pending output byte, then a clean image
    start_image(1'b0);
    give_key(23'd5, 23'd300, 23'd999);
    out_ready = 1'b0;
    send_pix(8'h10);
    pix_valid = 1'b0;
    @(negedge clk);
    check("D_pending_out", out_valid, 1);
    done_base = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("D_rst_key_ready", key_ready, 0);
    check("D_rst_pix_ready", pix_ready, 0);
    check("D_rst_out_valid", out_valid, 0);
    check("D_rst_out_data",  out_data,  0);
    check("D_rst_busy",      busy,      0);
    check("D_rst_done",      done,      0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    start_image(1'b0);
    give_key(23'd5, 23'd300, 23'd999);
    send_pix(8'h10);
    send_pix(8'h20);
    send_pix(8'hFF);
    give_key(23'h7, 23'h133, 23'h0);
    send_pix(8'h80);
    pix_valid = 1'b0;
    wait_done();
    check("D_one_done_after_abort", done_cnt - done_base, 1);
    check("D_queue_empty", exp_q.size(), 0);

    // E: back-to-back with key_valid held high
    key_valid = 1'b1;
    ex1 = 23'd5; ex2 = 23'd300; ex3 = 23'd999;
    mk[0] = kb(23'd5); mk[1] = kb(23'd300); mk[2] = kb(23'd999);
    acc_cyc.delete();
    start_image(1'b0);
    send_pix(8'h10);
    send_pix(8'h20);
    send_pix(8'hFF);
    send_pix(8'h80);
    pix_valid = 1'b0;
    wait_done();
    key_valid = 1'b0;
    check("E_out_count", acc_cyc.size(), 4);
    if (acc_cyc.size() >= 4) begin
      check("E_gap_0_1", acc_cyc[1] - acc_cyc[0], 1);
      check("E_gap_1_2", acc_cyc[2] - acc_cyc[1], 1);
      check("E_gap_2_3_one_bubble", acc_cyc[3] - acc_cyc[2], 2);
    end
    check("E_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
